// File: rtl/npc_pkg.sv
// Package shared by the next-PC slice.
// Holds the address width, the word-alignment mask applied to redirect
// targets and the fetch FSM state encoding.
package npc_pkg;

  localparam int          ADDR_W     = 32;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_VALID = 2'd1,
    S_ERR   = 2'd2
  } state_e;

endpackage

// File: rtl/next_pc_unit_if.sv
// Fetch/decode bus of the next-PC unit.
// Bundles the instruction-memory request channel (imem_req/imem_addr out,
// imem_ready/imem_rdata in) and the decode valid/ready channel
// (inst_valid/inst_word/inst_pc out, dec_ready in).
//   master : the next-PC unit (requests fetches, presents instructions)
//   slave  : the memory/decode side
interface next_pc_unit_if;
  import npc_pkg::*;

  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;
  logic [ADDR_W-1:0] imem_rdata;
  logic              inst_valid;
  logic [ADDR_W-1:0] inst_word;
  logic [ADDR_W-1:0] inst_pc;
  logic              dec_ready;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_word, inst_pc,
    input  imem_ready, imem_rdata, dec_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_word, inst_pc,
    output imem_ready, imem_rdata, dec_ready
  );

endinterface

// File: rtl/next_pc_unit_fetch_timeout_ctr.sv
// Fetch timeout counter.
// Counts cycles spent waiting for imem_ready. clr_i wins over inc_i.
// expire_o is high while the count equals TIMEOUT_CYCLES-1, i.e. during the
// last wait cycle allowed before the fetch is declared failed.
// Ports:
//   clock, reset_n : clock and synchronous active-low reset
//   clr_i          : return the count to zero
//   inc_i          : advance the count by one
//   expire_o       : final permitted wait cycle reached
module fetch_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = 8'd0;
    end else if (inc_i) begin
      count_d = count_q + 8'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expire_o = (count_q == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/next_pc_unit.sv
// Next-PC unit: closes the loop around an always-loading program counter.
// Fetches the word at inst_address, hands it to decode over valid/ready,
// and handles redirects and fetch timeouts. Since the PC has no enable,
// every hold is expressed as next_inst_address = inst_address.
// Ports:
//   clock, reset_n     : clock and synchronous active-low reset
//   inst_address       : current PC value
//   next_inst_address  : value the PC loads at the next posedge (comb.)
//   redirect_valid     : branch/jump taken this cycle
//   redirect_target    : new PC (low two bits ignored)
//   fetch_err          : sticky timeout flag (registered)
//   bus                : imem request channel and decode channel
module next_pc_unit
  import npc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
  parameter int          INST_STEP      = 4,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] inst_address,
  output logic [ADDR_W-1:0] next_inst_address,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              fetch_err,
  next_pc_unit_if.master    bus
);

  state_e            state_q;
  logic              inst_valid_q;
  logic [ADDR_W-1:0] inst_word_q;
  logic [ADDR_W-1:0] inst_pc_q;
  logic              fetch_err_q;

  logic in_fetch;
  logic capture;
  logic expire;

  assign in_fetch = (state_q == S_FETCH);
  // A redirect in the same cycle drops whatever the memory returned.
  assign capture  = in_fetch && bus.imem_ready && !redirect_valid;

  // The counter only advances while a fetch is waiting; anything else
  // (ready, redirect, leaving S_FETCH, expiry) returns it to zero.
  fetch_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clock   (clock),
    .reset_n (reset_n),
    .clr_i   (redirect_valid || !in_fetch || bus.imem_ready || expire),
    .inc_i   (in_fetch && !bus.imem_ready),
    .expire_o(expire)
  );

  // Next-address mux: reset > redirect > capture advance > hold.
  always_comb begin
    next_inst_address = inst_address;
    if (!reset_n) begin
      next_inst_address = RESET_VECTOR;
    end else if (redirect_valid) begin
      next_inst_address = redirect_target & ALIGN_MASK;
    end else if (capture) begin
      next_inst_address = inst_address + ADDR_W'(INST_STEP);
    end
  end

  assign bus.imem_req  = reset_n && in_fetch;
  assign bus.imem_addr = inst_address;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q      <= S_FETCH;
      inst_valid_q <= 1'b0;
      inst_word_q  <= '0;
      inst_pc_q    <= '0;
      fetch_err_q  <= 1'b0;
    end else if (redirect_valid) begin
      // Squash any presented instruction, even one accepted this cycle.
      state_q      <= S_FETCH;
      inst_valid_q <= 1'b0;
      fetch_err_q  <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (bus.imem_ready) begin
            inst_word_q  <= bus.imem_rdata;
            inst_pc_q    <= inst_address;
            inst_valid_q <= 1'b1;
            state_q      <= S_VALID;
          end else if (expire) begin
            fetch_err_q <= 1'b1;
            state_q     <= S_ERR;
          end
        end
        S_VALID: begin
          if (bus.dec_ready) begin
            inst_valid_q <= 1'b0;
            state_q      <= S_FETCH;
          end
        end
        S_ERR: begin
          inst_valid_q <= 1'b0;
        end
        default: begin
          inst_valid_q <= 1'b0;
          state_q      <= S_FETCH;
        end
      endcase
    end
  end

  assign bus.inst_valid = inst_valid_q;
  assign bus.inst_word  = inst_word_q;
  assign bus.inst_pc    = inst_pc_q;
  assign fetch_err      = fetch_err_q;

endmodule
